// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory responder for the single-cycle MIPS core.
// It contains a word-addressed data RAM and a memory-mapped peripheral page at
// 0xFFFF_xxxx. The page holds a GPIO register, a free-running cycle counter and
// a compare timer. Loads are combinational. Stores and peripheral state update
// on the rising clock edge.
// Build option: define DMEM_MMIO_TIMER_EN to implement the compare timer
// (TCMP/TCNT/TCTRL/TSTAT and timer_irq). When it is undefined, those offsets
// read 0 and timer_irq is tied low.

module dmem_mmio #(
    parameter int RAM_AW = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    // Word offsets (aluout[7:2]) inside the MMIO page
    localparam logic [5:0] OFF_GPIO  = 6'h00;
    localparam logic [5:0] OFF_CYCLE = 6'h01;
    localparam logic [5:0] OFF_TCMP  = 6'h02;
    localparam logic [5:0] OFF_TCNT  = 6'h03;
    localparam logic [5:0] OFF_TCTRL = 6'h04;
    localparam logic [5:0] OFF_TSTAT = 6'h05;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              is_mmio;
    logic [5:0]        mmio_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              mmio_we;

    assign is_mmio  = (aluout[31:16] == 16'hFFFF);
    assign mmio_off = aluout[7:2];
    // Upper RAM address bits are deliberately not checked, so RAM aliases.
    assign ram_idx  = aluout[RAM_AW+1:2];
    assign ram_we   = memwrite && !is_mmio;
    assign mmio_we  = memwrite && is_mmio;

    // The byte-lane bits and the unused part of the page offset are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aluout[15:8], aluout[1:0]};

    // ------------------------------------------------------------------
    // Data RAM
    // ------------------------------------------------------------------
    logic [31:0] ram [2**RAM_AW];

    // Synchronous RAM write port
    // NOTE: the RAM array is left out of the reset on purpose. Resetting a
    // memory turns it into a large bank of flops and prevents RAM inference.
    // Software must not assume the RAM holds known contents after power-up.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= writedata;
        end
    end

    // ------------------------------------------------------------------
    // GPIO and cycle counter
    // ------------------------------------------------------------------
    logic [31:0] gpio_q;
    logic [31:0] cycle_q;

    // GPIO register, loaded by stores to offset 0x00
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_q <= '0;
        end else if (mmio_we && (mmio_off == OFF_GPIO)) begin
            gpio_q <= writedata;
        end
    end

    // Free-running cycle counter. It is read-only, so stores are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign gpio_out = gpio_q;

`ifdef DMEM_MMIO_TIMER_EN
    // ------------------------------------------------------------------
    // Compare timer
    // ------------------------------------------------------------------
    typedef struct packed {
        logic irqen;
        logic autoreload;
        logic en;
    } tctrl_t;

    logic [31:0] tcmp_q, tcmp_n;
    logic [31:0] tcnt_q, tcnt_n;
    tctrl_t      tctrl_q, tctrl_n;
    logic        expired_q, expired_n;
    logic        irq_n;
    logic        match;

    assign match = tctrl_q.en && (tcnt_q == tcmp_q);

    // Next timer state: the timer's own update first, then CPU stores
    // override it. A match still sets EXPIRED, and that set beats a W1C clear.
    // NOTE: every variable gets a default first, so no path through this
    // block leaves a value unassigned and no latch is inferred.
    always_comb begin
        tcmp_n    = tcmp_q;
        tcnt_n    = tcnt_q;
        tctrl_n   = tctrl_q;
        expired_n = expired_q;

        if (tctrl_q.en) begin
            if (match) begin
                if (tctrl_q.autoreload) begin
                    tcnt_n = '0;
                end else begin
                    tctrl_n.en = 1'b0;
                end
            end else begin
                tcnt_n = tcnt_q + 32'd1;
            end
        end

        if (mmio_we) begin
            case (mmio_off)
                OFF_TCMP:  tcmp_n  = writedata;
                OFF_TCNT:  tcnt_n  = writedata;
                OFF_TCTRL: tctrl_n = tctrl_t'(writedata[2:0]);
                OFF_TSTAT: if (writedata[0]) expired_n = 1'b0;
                default:   ;
            endcase
        end

        if (match) begin
            expired_n = 1'b1;
        end

        irq_n = expired_n && tctrl_n.irqen;
    end

    // Timer register bank and the registered interrupt output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcmp_q    <= 32'hFFFF_FFFF;
            tcnt_q    <= '0;
            tctrl_q   <= '0;
            expired_q <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            tcmp_q    <= tcmp_n;
            tcnt_q    <= tcnt_n;
            tctrl_q   <= tctrl_n;
            expired_q <= expired_n;
            timer_irq <= irq_n;
        end
    end
`else
    assign timer_irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Combinational load path
    // ------------------------------------------------------------------
    // Load mux: RAM word or MMIO register. Unmapped offsets read 0.
    always_comb begin
        readdata = '0;
        if (is_mmio) begin
            case (mmio_off)
                OFF_GPIO:  readdata = gpio_q;
                OFF_CYCLE: readdata = cycle_q;
`ifdef DMEM_MMIO_TIMER_EN
                OFF_TCMP:  readdata = tcmp_q;
                OFF_TCNT:  readdata = tcnt_q;
                OFF_TCTRL: readdata = {29'd0, tctrl_q};
                OFF_TSTAT: readdata = {31'd0, expired_q};
`endif
                default:   readdata = '0;
            endcase
        end else begin
            readdata = ram[ram_idx];
        end
    end

endmodule
